// File: rtl/game_timer_if.sv
// game_timer_if: control pulses into the stopwatch and its display/status outputs.
interface game_timer_if;
    logic        start;
    logic        pause;
    logic        solved;
    logic        clear;
    logic [15:0] displayed_number;
    logic        running;
    logic        stopped;
    logic        saturated;
    modport master (output start, pause, solved, clear,
                    input  displayed_number, running, stopped, saturated);
    modport slave  (input  start, pause, solved, clear,
                    output displayed_number, running, stopped, saturated);
endinterface

// File: rtl/game_timer.sv
// game_timer: MM:SS elapsed-time stopwatch feeding the display as minutes*100+seconds.
module game_timer #(
    parameter int TICK_DIV = 100_000_000,
    parameter int MAX_MIN  = 99
) (
    input logic         clk,
    input logic         rst_n,
    game_timer_if.slave bus
);
    localparam int PW = $clog2(TICK_DIV);
    typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, STOPPED} state_t;
    state_t          state_q, state_d;
    logic [6:0]      min_q, min_d;
    logic [5:0]      sec_q, sec_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [15:0]     disp_q, disp_d;
    logic            running_q, running_d;
    logic            stopped_q, stopped_d;
    logic            saturated_q, saturated_d;
    logic            tick, at_max;
    always_comb begin
        tick    = state_q == RUNNING && presc_q == PW'(TICK_DIV - 1);
        at_max  = min_q == 7'(MAX_MIN) && sec_q == 6'd59;
        state_d = state_q;
        min_d   = min_q;
        sec_d   = sec_q;
        presc_d = presc_q;
        if (bus.clear) begin
            state_d = IDLE;
            min_d   = '0;
            sec_d   = '0;
            presc_d = '0;
        end else begin
            case (state_q)
                IDLE: if (bus.start) begin
                    state_d = RUNNING;
                    presc_d = '0;
                end
                RUNNING: begin
                    presc_d = tick ? '0 : presc_q + 1'b1;
                    // a tick landing on a pause/solved pulse is dropped, not deferred
                    if (bus.solved) state_d = STOPPED;
                    else if (bus.pause) state_d = PAUSED;
                    else if (tick && !at_max) begin
                        sec_d = sec_q == 6'd59 ? 6'd0 : sec_q + 6'd1;
                        min_d = sec_q == 6'd59 ? min_q + 7'd1 : min_q;
                    end
                end
                PAUSED: state_d = bus.solved ? STOPPED : bus.pause ? RUNNING : PAUSED;
                default: state_d = STOPPED;
            endcase
        end
        disp_d      = 16'(min_d) * 16'd100 + 16'(sec_d);
        running_d   = state_d == RUNNING;
        stopped_d   = state_d == STOPPED;
        saturated_d = min_d == 7'(MAX_MIN) && sec_d == 6'd59;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            min_q       <= '0;
            sec_q       <= '0;
            presc_q     <= '0;
            disp_q      <= '0;
            running_q   <= 1'b0;
            stopped_q   <= 1'b0;
            saturated_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            presc_q     <= presc_d;
            disp_q      <= disp_d;
            running_q   <= running_d;
            stopped_q   <= stopped_d;
            saturated_q <= saturated_d;
        end
    end
    assign bus.displayed_number = disp_q;
    assign bus.running          = running_q;
    assign bus.stopped          = stopped_q;
    assign bus.saturated        = saturated_q;
endmodule

// File: tb/tb_game_timer.sv
// tb_game_timer: scoreboard bench; stimulus pushes expected outputs, a monitor pops and compares.
module tb_game_timer;
    localparam int TD  = 4;
    localparam int MM  = 99;
    localparam int CAP = MM * 60 + 59;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    game_timer_if bus();
    game_timer #(.TICK_DIV(TD), .MAX_MIN(MM)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    logic [18:0] dut_v;
    assign dut_v = {bus.displayed_number, bus.running, bus.stopped, bus.saturated};
    logic [18:0] q[$];
    int checks = 0;
    int passes = 0;
    int ms = 0;
    int secs = 0;
    int pr = 0;
    task automatic chk(input string n, input logic [18:0] act, input logic [18:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got disp=%0d run=%b stop=%b sat=%b, expected disp=%0d run=%b stop=%b sat=%b",
                      n, act[18:3], act[2], act[1], act[0], exp[18:3], exp[2], exp[1], exp[0]);
    endtask
    function automatic logic [18:0] pk(input int d, input logic r, input logic s, input logic sat);
        return {16'(d), r, s, sat};
    endfunction
    function automatic logic [18:0] model_out();
        return pk((secs / 60) * 100 + secs % 60, ms == 1, ms == 3, secs == CAP);
    endfunction
    task automatic model(input logic st, input logic pa, input logic so, input logic cl);
        bit adv;
        if (cl) begin
            ms = 0; secs = 0; pr = 0;
        end else if (ms == 0) begin
            if (st) begin ms = 1; pr = 0; end
        end else if (ms == 1) begin
            adv = pr == TD - 1;
            pr = (pr + 1) % TD;
            if (so) ms = 3;
            else if (pa) ms = 2;
            else if (adv && secs < CAP) secs++;
        end else if (ms == 2) begin
            if (so) ms = 3;
            else if (pa) ms = 1;
        end
    endtask
    task automatic step(input logic st, input logic pa, input logic so, input logic cl);
        @(negedge clk);
        bus.start = st; bus.pause = pa; bus.solved = so; bus.clear = cl;
        model(st, pa, so, cl);
        q.push_back(model_out());
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask
    task automatic expect_now(input string n, input int d, input logic r, input logic s, input logic sat);
        @(posedge clk);
        #2 chk(n, dut_v, pk(d, r, s, sat));
    endtask
    task automatic do_reset(input int n);
        @(negedge clk);
        rst_n = 1'b0;
        bus.start = 0; bus.pause = 0; bus.solved = 0; bus.clear = 0;
        ms = 0; secs = 0; pr = 0;
        #1 chk("async_reset", dut_v, '0);
        q.push_back('0);
        for (int i = 1; i < n; i++) begin
            @(negedge clk);
            q.push_back('0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        q.push_back(model_out());
    endtask
    task automatic run_until(input string n, input int target, input int budget);
        int k = 0;
        while (secs != target && k < budget) begin
            step(0, 0, 0, 0);
            k++;
        end
        if (secs != target) chk(n, 19'(secs), 19'(target));
    endtask
    initial begin
        logic [18:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("cycle", dut_v, e);
            end
        end
    end
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end
    initial begin
        bus.start = 0; bus.pause = 0; bus.solved = 0; bus.clear = 0;
        do_reset(2);
        expect_now("reset_idle", 0, 0, 0, 0);
        // 1: reset mid-run at 00:07
        step(1, 0, 0, 0);
        run_until("reach_7s", 7, 100);
        expect_now("at_7s", 7, 1, 0, 0);
        do_reset(3);
        expect_now("after_reset", 0, 0, 0, 0);
        // 2: 61 ticks -> 01:01
        step(1, 0, 0, 0);
        idle(244);
        expect_now("run_61", 101, 1, 0, 0);
        // 3: pause holds the prescaler
        step(0, 0, 0, 1);
        step(1, 0, 0, 0);
        idle(12);
        step(0, 1, 0, 0);
        idle(40);
        expect_now("paused", 3, 0, 0, 0);
        step(0, 1, 0, 0);
        idle(2);
        expect_now("resume_pre_tick", 3, 1, 0, 0);
        idle(1);
        expect_now("resume_tick", 4, 1, 0, 0);
        idle(4);
        expect_now("resume_5", 5, 1, 0, 0);
        // 4: saturation at 99:59
        step(0, 0, 0, 1);
        step(1, 0, 0, 0);
        run_until("reach_9958", CAP - 1, 30000);
        expect_now("at_9958", 9958, 1, 0, 0);
        run_until("reach_9959", CAP, 8);
        expect_now("at_9959", 9959, 1, 0, 1);
        idle(40);
        expect_now("held_9959", 9959, 1, 0, 1);
        // 5: solved beats pause; STOPPED ignores start/pause
        step(0, 0, 0, 1);
        step(1, 0, 0, 0);
        idle(20);
        step(0, 1, 1, 0);
        expect_now("solved", 5, 0, 1, 0);
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        idle(8);
        expect_now("stopped_frozen", 5, 0, 1, 0);
        step(0, 0, 0, 1);
        expect_now("stop_clear", 0, 0, 0, 0);
        // 6: clear beats start
        step(1, 0, 0, 1);
        expect_now("clear_start", 0, 0, 0, 0);
        idle(8);
        expect_now("still_idle", 0, 0, 0, 0);
        // random pulses against the model
        for (int i = 0; i < 4000; i++)
            step($urandom_range(0, 14) == 0, $urandom_range(0, 24) == 0,
                 $urandom_range(0, 199) == 0, $urandom_range(0, 299) == 0);
        idle(3);
        @(posedge clk);
        #3 chk("drain", 19'(q.size()), '0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
